// File: rtl/seq_mult_pkg.sv
// Shared definitions for the shift-and-add sequential multiplier:
// control state encodings, the default operand width and a helper
// for sizing the bit counter.
package seq_mult_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEFAULT_N = 4;

    // Control states. The encodings are fixed so that debug views of the
    // state register decode the same way in every build.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter width able to hold the value n (the counter is loaded with N
    // and counts down to 1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Control sequencer for the shift-and-add multiplier. Owns the state
// register and the bit counter, and decodes the per-cycle register
// strobes (clear, load, add, shift) that drive the datapath.
//
// Sequence per operation: IDLE (accept) -> N x (ADD, SHIFT) -> DONE -> IDLE.
// The counter is loaded with N on accept and decremented on every SHIFT;
// the SHIFT that sees cnt==1 is the last one, so the counter never wraps.
module mult_ctrl_fsm
    import seq_mult_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int CW = cnt_width(N)
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic q0,
    output logic clr,
    output logic ld,
    output logic add,
    output logic shft,
    output logic busy,
    output logic done
);

    localparam logic [CW-1:0] CNT_LOAD = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            cnt_is_one;

    assign cnt_is_one = (cnt == CNT_ONE);

    // State and bit counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ADD;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_ADD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                cnt_nxt   = cnt - CNT_ONE;
                state_nxt = cnt_is_one ? ST_DONE : ST_ADD;
            end
            ST_DONE: begin
                // Start presented here is deliberately ignored; the host
                // must present it again once the block is back in IDLE.
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobe decode: clear/load fire combinationally on an accepted start,
    // add only when the current multiplier LSB is set.
    always_comb begin
        clr  = 1'b0;
        ld   = 1'b0;
        add  = 1'b0;
        shft = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_IDLE: begin
                clr = start;
                ld  = start;
            end
            ST_ADD: begin
                add  = q0;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                shft = 1'b1;
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                clr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-and-add unsigned sequential multiplier: control sequencer plus
// the A/E/Q/M datapath. The product is the concatenation {A,Q}.
//
// Host handshake: start is a request sampled only while idle; a start seen
// while busy or during the done cycle is dropped, not queued. Operands are
// captured on the accepting edge and may change afterwards. done is a
// single-cycle pulse marking product valid; product then holds until the
// next accepted start.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [N-1:0]     mcand,
    input  logic [N-1:0]     mplier,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic             clr_rg,
    output logic             ld_rg,
    output logic             add_rg,
    output logic             shft_rt
);

    logic [N-1:0] a;
    logic [N-1:0] q;
    logic [N-1:0] m;
    logic         e;
    logic [N:0]   sum;

    // Full N+1-bit sum so the carry lands in E; A+M never exceeds N+1 bits.
    assign sum = {1'b0, a} + {1'b0, m};

    mult_ctrl_fsm #(
        .N (N)
    ) u_fsm (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .q0     (q[0]),
        .clr    (clr_rg),
        .ld     (ld_rg),
        .add    (add_rg),
        .shft   (shft_rt),
        .busy   (busy),
        .done   (done)
    );

    // Accumulator A and carry E: cleared on accept, loaded with the sum on
    // add, and shifted right (E into A's MSB, zero into E) on shift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a <= '0;
            e <= 1'b0;
        end else if (clr_rg) begin
            a <= '0;
            e <= 1'b0;
        end else if (add_rg) begin
            e <= sum[N];
            a <= sum[N-1:0];
        end else if (shft_rt) begin
            e <= 1'b0;
            a <= {e, a[N-1:1]};
        end
    end

    // Multiplier Q: loaded on accept, receives A's LSB on every shift so the
    // low half of the product accumulates here as multiplier bits retire.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= '0;
        end else if (ld_rg) begin
            q <= mplier;
        end else if (shft_rt) begin
            q <= {a[0], q[N-1:1]};
        end
    end

    // Multiplicand M: captured on accept and held for the whole operation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m <= '0;
        end else if (ld_rg) begin
            m <= mcand;
        end
    end

    assign product = {a, q};

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl (N=4): a table of operand pairs with
// hand-computed products and add-strobe traces, followed by hand-written
// sequences for held start, mid-operation reset and idle hold.
module tb_seq_mult_ctrl;

    localparam int N = 4;
    localparam int DONE_CYC = 2 * N + 1;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [N-1:0] mcand;
    logic [N-1:0] mplier;
    logic         busy;
    logic         done;
    logic [2*N-1:0] product;
    logic         clr_rg;
    logic         ld_rg;
    logic         add_rg;
    logic         shft_rt;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] mc;
        logic [3:0] mp;
        logic [7:0] prod;
        logic [3:0] trace;
    } vec_t;

    vec_t vecs[8];

    seq_mult_ctrl #(
        .N (N)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .clr_rg  (clr_rg),
        .ld_rg   (ld_rg),
        .add_rg  (add_rg),
        .shft_rt (shft_rt)
    );

    // Clock: 20 ns period, first rising edge at 10 ns.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One complete operation: present start for one cycle, then follow the
    // operation cycle by cycle (c=1 is the first cycle after the accepting
    // edge; ADD on odd c, SHIFT on even c, done expected at c=2N+1).
    task automatic run_op(input logic [3:0] mc, input logic [3:0] mp,
                          input logic [7:0] exp_p, input logic [3:0] exp_tr,
                          input string tag);
        int         done_c;
        int         shfts;
        int         busy_bad;
        logic [3:0] tr;
        logic [7:0] p_at_done;
        logic       busy_at_done;
        @(negedge clk);
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        #1;
        check({tag, ":clr_on_accept"}, 32'(clr_rg), 32'd1);
        check({tag, ":ld_on_accept"}, 32'(ld_rg), 32'd1);
        @(posedge clk);
        done_c = 0;
        shfts = 0;
        busy_bad = 0;
        tr = 4'd0;
        p_at_done = 8'd0;
        busy_at_done = 1'b1;
        for (int c = 1; c <= 20 && done_c == 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_c = c;
                p_at_done = product;
                busy_at_done = busy;
            end
            if ((c % 2) == 1 && c <= 2 * N - 1) tr[(c - 1) / 2] = add_rg;
            if (shft_rt === 1'b1) shfts++;
            if (c <= 2 * N && busy !== 1'b1) busy_bad++;
            if (c == 1) begin
                start  = 1'b0;
                mcand  = ~mc;
                mplier = ~mp;
            end
        end
        check({tag, ":done_cycle"}, 32'(done_c), 32'(DONE_CYC));
        check({tag, ":product"}, 32'(p_at_done), 32'(exp_p));
        check({tag, ":add_trace"}, 32'(tr), 32'(exp_tr));
        check({tag, ":shift_count"}, 32'(shfts), 32'(N));
        check({tag, ":busy_during_op"}, 32'(busy_bad), 32'd0);
        check({tag, ":busy_at_done"}, 32'(busy_at_done), 32'd0);
        @(negedge clk);
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
        check({tag, ":product_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int         d_cnt;
        int         clr_bad;
        int         d_cyc[4];
        logic [7:0] d_prod[4];
        int         rst_dones;

        checks = 0;
        errors = 0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        resetn = 1'b0;

        // Hand-computed vectors; the add trace is Q[0] at each ADD, i.e. the
        // multiplier bits LSB first.
        vecs[0] = '{mc: 4'd10, mp: 4'd11, prod: 8'd110, trace: 4'b1011};
        vecs[1] = '{mc: 4'd15, mp: 4'd15, prod: 8'hE1,  trace: 4'b1111};
        vecs[2] = '{mc: 4'd0,  mp: 4'd9,  prod: 8'd0,   trace: 4'b1001};
        vecs[3] = '{mc: 4'd9,  mp: 4'd0,  prod: 8'd0,   trace: 4'b0000};
        vecs[4] = '{mc: 4'd7,  mp: 4'd9,  prod: 8'd63,  trace: 4'b1001};
        vecs[5] = '{mc: 4'd1,  mp: 4'd1,  prod: 8'd1,   trace: 4'b0001};
        vecs[6] = '{mc: 4'd12, mp: 4'd5,  prod: 8'd60,  trace: 4'b0101};
        vecs[7] = '{mc: 4'd15, mp: 4'd1,  prod: 8'd15,  trace: 4'b0001};

        // Reset state, checked while reset is still asserted.
        #2;
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        check("reset:product", 32'(product), 32'd0);
        check("reset:clr", 32'(clr_rg), 32'd0);
        check("reset:ld", 32'(ld_rg), 32'd0);
        check("reset:add", 32'(add_rg), 32'd0);
        check("reset:shft", 32'(shft_rt), 32'd0);
        #3;
        resetn = 1'b1;

        // Table-driven operations.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].mc, vecs[i].mp, vecs[i].prod, vecs[i].trace, $sformatf("vec%0d", i));
        end

        // Start held high: one operation every 2N+2 cycles, start ignored
        // while busy or in DONE, operand change mid-operation only affects
        // the next accepted operation (3*5=15, then 15*5=75 twice).
        @(negedge clk);
        mcand  = 4'd3;
        mplier = 4'd5;
        start  = 1'b1;
        @(posedge clk);
        d_cnt = 0;
        clr_bad = 0;
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            if (done === 1'b1 && d_cnt < 4) begin
                d_cyc[d_cnt]  = c;
                d_prod[d_cnt] = product;
                d_cnt++;
            end
            if ((busy === 1'b1 || done === 1'b1) && clr_rg !== 1'b0) clr_bad++;
            if (c == 4) mcand = 4'd15;
            if (c == 29) start = 1'b0;
        end
        check("held:done_count", 32'(d_cnt), 32'd3);
        if (d_cnt >= 3) begin
            check("held:done1_cycle", 32'(d_cyc[0]), 32'd9);
            check("held:done2_cycle", 32'(d_cyc[1]), 32'd19);
            check("held:done3_cycle", 32'(d_cyc[2]), 32'd29);
            check("held:prod1", 32'(d_prod[0]), 32'd15);
            check("held:prod2", 32'(d_prod[1]), 32'd75);
            check("held:prod3", 32'(d_prod[2]), 32'd75);
        end
        check("held:clr_while_busy", 32'(clr_bad), 32'd0);
        @(negedge clk);
        check("held:idle_after", 32'(busy), 32'd0);

        // Reset asserted during the first SHIFT of an operation.
        @(negedge clk);
        mcand  = 4'd13;
        mplier = 4'd11;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst:in_shift", 32'(shft_rt), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:product", 32'(product), 32'd0);
        check("rst:shft", 32'(shft_rt), 32'd0);
        check("rst:add", 32'(add_rg), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        rst_dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) rst_dones++;
        end
        check("rst:no_activity", 32'(rst_dones), 32'd0);
        run_op(4'd7, 4'd9, 8'd63, 4'b1001, "rst_recover");

        // Idle with start low: nothing moves, product holds 63.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("idle:busy", 32'(busy), 32'd0);
            check("idle:done", 32'(done), 32'd0);
            check("idle:product", 32'(product), 32'd63);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule
